// File: rtl/rob_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_param_pkg
// Brief    : Shared opType codes, commit FSM states and store-size encoding
//            for the parametrised reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
package rob_param_pkg;

    localparam int c_OPC_W = 6;
    typedef logic [c_OPC_W-1:0] opc_t;

    localparam opc_t c_OP_LUI  = 6'd1;
    localparam opc_t c_OP_JAL  = 6'd2;
    localparam opc_t c_OP_JALR = 6'd3;
    localparam opc_t c_OP_BEQ  = 6'd4;
    localparam opc_t c_OP_BNE  = 6'd5;
    localparam opc_t c_OP_BLT  = 6'd6;
    localparam opc_t c_OP_BGE  = 6'd7;
    localparam opc_t c_OP_BLTU = 6'd8;
    localparam opc_t c_OP_BGEU = 6'd9;
    localparam opc_t c_OP_LW   = 6'd12;
    localparam opc_t c_OP_SB   = 6'd16;
    localparam opc_t c_OP_SH   = 6'd17;
    localparam opc_t c_OP_SW   = 6'd18;
    localparam opc_t c_OP_ADDI = 6'd19;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_WAIT  = 2'd1;
    localparam state_t c_ST_FLUSH = 2'd2;

    localparam logic [2:0] c_SZ_B = 3'd1;
    localparam logic [2:0] c_SZ_H = 3'd2;
    localparam logic [2:0] c_SZ_W = 3'd4;

    function automatic logic is_store(input opc_t op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    function automatic logic is_jump(input opc_t op);
        return (op == c_OP_JAL) || (op == c_OP_JALR);
    endfunction

    function automatic logic [2:0] st_size_of(input opc_t op);
        case (op)
            c_OP_SB: return c_SZ_B;
            c_OP_SH: return c_SZ_H;
            default: return c_SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_param_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_param_if
// Brief    : Bundle of decoder, writeback, CDB, commit, store and redirect
//            signals around the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface rob_param_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6,
    parameter int REG_W  = 5
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              rdy;
    logic              clear;
    logic              alloc_valid;
    logic [OP_W-1:0]   alloc_op;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  q1_tag, q2_tag;
    logic              q1_ready, q2_ready;
    logic [DATA_W-1:0] q1_data, q2_data;
    logic              ex_wb_valid;
    logic [TAG_W-1:0]  ex_wb_tag;
    logic [DATA_W-1:0] ex_wb_data;
    logic [ADDR_W-1:0] ex_wb_npc;
    logic              ex_wb_redirect;
    logic              lsb_wb_valid;
    logic [TAG_W-1:0]  lsb_wb_tag;
    logic [DATA_W-1:0] lsb_wb_data;
    logic [ADDR_W-1:0] lsb_wb_addr;
    logic              cdb_ex_valid, cdb_lsb_valid;
    logic [TAG_W-1:0]  cdb_ex_tag, cdb_lsb_tag;
    logic [DATA_W-1:0] cdb_ex_data, cdb_lsb_data;
    logic              commit_valid;
    logic [REG_W-1:0]  commit_rd;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [2:0]        st_size;
    logic              st_done;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_out;
    logic [ADDR_W-1:0] hzd_addr;
    logic              hzd;
    logic [TAG_W:0]    count;

    modport master (
        output rdy, clear, alloc_valid, alloc_op, alloc_rd, q1_tag, q2_tag,
               ex_wb_valid, ex_wb_tag, ex_wb_data, ex_wb_npc, ex_wb_redirect,
               lsb_wb_valid, lsb_wb_tag, lsb_wb_data, lsb_wb_addr, st_done, hzd_addr,
        input  alloc_ready, alloc_tag, q1_ready, q2_ready, q1_data, q2_data,
               cdb_ex_valid, cdb_ex_tag, cdb_ex_data, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
               commit_valid, commit_rd, commit_tag, commit_data,
               st_req, st_addr, st_data, st_size, redirect_valid, redirect_pc,
               flush_out, hzd, count
    );

    modport slave (
        input  rdy, clear, alloc_valid, alloc_op, alloc_rd, q1_tag, q2_tag,
               ex_wb_valid, ex_wb_tag, ex_wb_data, ex_wb_npc, ex_wb_redirect,
               lsb_wb_valid, lsb_wb_tag, lsb_wb_data, lsb_wb_addr, st_done, hzd_addr,
        output alloc_ready, alloc_tag, q1_ready, q2_ready, q1_data, q2_data,
               cdb_ex_valid, cdb_ex_tag, cdb_ex_data, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
               commit_valid, commit_rd, commit_tag, commit_data,
               st_req, st_addr, st_data, st_size, redirect_valid, redirect_pc,
               flush_out, hzd, count
    );

endinterface
`default_nettype wire

// File: rtl/rob_param_hzd_cam.sv
`default_nettype none
// ============================================================================
// Module   : rob_hzd_cam
// Brief    : Word-address compare of a probed load address against every
//            valid store entry; hit if any entry matches.
// Revision : 1.0 - initial release
// ============================================================================
module rob_hzd_cam #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  wire logic [DEPTH-1:0]             i_vld,
    input  wire logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  wire logic [ADDR_W-1:0]            i_probe,
    output logic                              o_hit
);
    // Byte offset bits are masked so any byte in the same word hits.
    localparam logic [ADDR_W-1:0] c_WORD_MASK = ~ADDR_W'(3);

    logic [DEPTH-1:0] w_match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_match[gi] = i_vld[gi] &&
                             (((i_addr[gi] ^ i_probe) & c_WORD_MASK) == '0);
    end

    assign o_hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
// Module   : rob_param
// Brief    : Parametrised reorder buffer with dual writeback/CDB ports,
//            in-order commit, store retirement and redirect flush.
//            Optional macro ROB_WB_BYPASS_EN: same-cycle writeback bypass
//            into the operand lookups.
// Revision : 1.0 - initial release
// ============================================================================
module rob_param
    import rob_param_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6,
    parameter int REG_W  = 5
) (
    input wire logic   clk,
    input wire logic   rst,
    rob_param_if.slave bus
);
    localparam int             TAG_W  = $clog2(DEPTH);
    localparam logic [TAG_W:0] c_FULL = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]             r_busy, r_ready, r_redir;
    logic [DEPTH-1:0][OP_W-1:0]   r_op;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [REG_W-1:0]             r_rd  [DEPTH];
    logic [DATA_W-1:0]            r_val [DEPTH];
    logic [ADDR_W-1:0]            r_npc [DEPTH];
    logic [TAG_W-1:0]             r_head, r_tail;
    logic [TAG_W:0]               r_count;
    state_t                       r_state, w_state_nxt;

    logic             w_alloc, w_ex_wr, w_lsb_wr;
    logic             w_retire, w_do_commit, w_do_store, w_do_redir, w_do_flush;
    logic             w_head_rdy, w_hzd;
    opc_t             w_head_op;
    logic [DEPTH-1:0] w_rb, w_is_st;

    assign w_rb       = r_busy & r_ready;
    assign w_head_rdy = w_rb[r_head];
    assign w_head_op  = opc_t'(r_op[r_head]);

    assign bus.alloc_ready = (r_count != c_FULL) && (r_state != c_ST_FLUSH);
    assign bus.alloc_tag   = r_tail;
    assign bus.count       = r_count;

    assign w_alloc  = bus.alloc_valid && bus.alloc_ready;
    assign w_ex_wr  = bus.ex_wb_valid && r_busy[bus.ex_wb_tag];
    // EX owns the entry when both ports target the same tag.
    assign w_lsb_wr = bus.lsb_wb_valid && r_busy[bus.lsb_wb_tag] &&
                      !(w_ex_wr && (bus.ex_wb_tag == bus.lsb_wb_tag));

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_state <= c_ST_IDLE;
        end else if (bus.rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_do_commit = 1'b0;
        w_do_store  = 1'b0;
        w_do_redir  = 1'b0;
        w_do_flush  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_head_rdy) begin
                    if (is_store(w_head_op)) begin
                        w_do_store  = 1'b1;
                        w_state_nxt = c_ST_WAIT;
                    end else if (!r_redir[r_head]) begin
                        w_do_commit = 1'b1;
                        w_retire    = 1'b1;
                    end else begin
                        w_do_commit = is_jump(w_head_op);
                        w_do_redir  = 1'b1;
                        w_state_nxt = c_ST_FLUSH;
                    end
                end
            end
            c_ST_WAIT: begin
                if (bus.st_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_FLUSH: begin
                w_do_flush  = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_busy             <= '0;
            r_ready            <= '0;
            r_redir            <= '0;
            r_head             <= '0;
            r_tail             <= '0;
            r_count            <= '0;
            bus.cdb_ex_valid   <= 1'b0;
            bus.cdb_ex_tag     <= '0;
            bus.cdb_ex_data    <= '0;
            bus.cdb_lsb_valid  <= 1'b0;
            bus.cdb_lsb_tag    <= '0;
            bus.cdb_lsb_data   <= '0;
            bus.commit_valid   <= 1'b0;
            bus.commit_rd      <= '0;
            bus.commit_tag     <= '0;
            bus.commit_data    <= '0;
            bus.st_req         <= 1'b0;
            bus.st_addr        <= '0;
            bus.st_data        <= '0;
            bus.st_size        <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.flush_out      <= 1'b0;
        end else begin
            bus.cdb_ex_valid   <= 1'b0;
            bus.cdb_lsb_valid  <= 1'b0;
            bus.commit_valid   <= 1'b0;
            bus.st_req         <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.flush_out      <= 1'b0;
            if (bus.rdy) begin
                if (w_do_flush) begin
                    r_busy        <= '0;
                    r_ready       <= '0;
                    r_redir       <= '0;
                    r_head        <= '0;
                    r_tail        <= '0;
                    r_count       <= '0;
                    bus.flush_out <= 1'b1;
                end else begin
                    if (w_alloc) begin
                        r_busy[r_tail]  <= 1'b1;
                        r_ready[r_tail] <= 1'b0;
                        r_redir[r_tail] <= 1'b0;
                        r_op[r_tail]    <= bus.alloc_op;
                        r_rd[r_tail]    <= bus.alloc_rd;
                        r_tail          <= r_tail + 1'b1;
                    end
                    if (w_ex_wr) begin
                        r_val[bus.ex_wb_tag]   <= bus.ex_wb_data;
                        r_npc[bus.ex_wb_tag]   <= bus.ex_wb_npc;
                        r_redir[bus.ex_wb_tag] <= bus.ex_wb_redirect;
                        r_ready[bus.ex_wb_tag] <= 1'b1;
                        bus.cdb_ex_valid       <= 1'b1;
                        bus.cdb_ex_tag         <= bus.ex_wb_tag;
                        bus.cdb_ex_data        <= bus.ex_wb_data;
                    end
                    if (w_lsb_wr) begin
                        r_val[bus.lsb_wb_tag]   <= bus.lsb_wb_data;
                        r_ready[bus.lsb_wb_tag] <= 1'b1;
                        if (is_store(opc_t'(r_op[bus.lsb_wb_tag]))) begin
                            r_addr[bus.lsb_wb_tag] <= bus.lsb_wb_addr;
                        end
                        bus.cdb_lsb_valid <= 1'b1;
                        bus.cdb_lsb_tag   <= bus.lsb_wb_tag;
                        bus.cdb_lsb_data  <= bus.lsb_wb_data;
                    end
                    if (w_do_commit) begin
                        bus.commit_valid <= 1'b1;
                        bus.commit_rd    <= r_rd[r_head];
                        bus.commit_tag   <= r_head;
                        bus.commit_data  <= r_val[r_head];
                    end
                    if (w_do_store) begin
                        bus.st_req  <= 1'b1;
                        bus.st_addr <= r_addr[r_head];
                        bus.st_data <= r_val[r_head];
                        bus.st_size <= st_size_of(w_head_op);
                    end
                    if (w_do_redir) begin
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= r_npc[r_head];
                    end
                    if (w_retire) begin
                        r_busy[r_head] <= 1'b0;
                        r_head         <= r_head + 1'b1;
                    end
                    r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
                end
            end
        end
    end

    // Ready is an explicit bit, so a stored zero still reads as available.
    always_comb begin
        bus.q1_ready = w_rb[bus.q1_tag];
        bus.q1_data  = w_rb[bus.q1_tag] ? r_val[bus.q1_tag] : '0;
        bus.q2_ready = w_rb[bus.q2_tag];
        bus.q2_data  = w_rb[bus.q2_tag] ? r_val[bus.q2_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (bus.rdy && w_ex_wr && (bus.ex_wb_tag == bus.q1_tag)) begin
            bus.q1_ready = 1'b1;
            bus.q1_data  = bus.ex_wb_data;
        end else if (bus.rdy && w_lsb_wr && (bus.lsb_wb_tag == bus.q1_tag)) begin
            bus.q1_ready = 1'b1;
            bus.q1_data  = bus.lsb_wb_data;
        end
        if (bus.rdy && w_ex_wr && (bus.ex_wb_tag == bus.q2_tag)) begin
            bus.q2_ready = 1'b1;
            bus.q2_data  = bus.ex_wb_data;
        end else if (bus.rdy && w_lsb_wr && (bus.lsb_wb_tag == bus.q2_tag)) begin
            bus.q2_ready = 1'b1;
            bus.q2_data  = bus.lsb_wb_data;
        end
`endif
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_st_vld
        assign w_is_st[gi] = is_store(opc_t'(r_op[gi]));
    end

    rob_hzd_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_hzd_cam (
        .i_vld   (w_rb & w_is_st),
        .i_addr  (r_addr),
        .i_probe (bus.hzd_addr),
        .o_hit   (w_hzd)
    );

    assign bus.hzd = w_hzd;

endmodule
`default_nettype wire

// File: tb/tb_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_param
// Brief    : Directed self-checking bench for rob_param at DEPTH = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_param;
    import rob_param_pkg::*;

`ifdef ROB_WB_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    rob_param_if #(.DEPTH(4)) bus ();

    rob_param #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input opc_t op, input logic [4:0] rd);
        bus.alloc_valid = 1'b1;
        bus.alloc_op    = op;
        bus.alloc_rd    = rd;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic ex_wb(input logic [1:0] tag, input logic [31:0] data,
                         input logic [31:0] npc, input logic redir);
        bus.ex_wb_valid    = 1'b1;
        bus.ex_wb_tag      = tag;
        bus.ex_wb_data     = data;
        bus.ex_wb_npc      = npc;
        bus.ex_wb_redirect = redir;
    endtask

    task automatic lsb_wb(input logic [1:0] tag, input logic [31:0] data, input logic [31:0] addr);
        bus.lsb_wb_valid = 1'b1;
        bus.lsb_wb_tag   = tag;
        bus.lsb_wb_data  = data;
        bus.lsb_wb_addr  = addr;
    endtask

    task automatic wb_idle();
        bus.ex_wb_valid  = 1'b0;
        bus.lsb_wb_valid = 1'b0;
    endtask

    initial begin
        bus.rdy = 1'b1;           bus.clear = 1'b0;
        bus.alloc_valid = 1'b0;   bus.alloc_op = '0;   bus.alloc_rd = '0;
        bus.q1_tag = '0;          bus.q2_tag = '0;
        bus.ex_wb_valid = 1'b0;   bus.ex_wb_tag = '0;  bus.ex_wb_data = '0;
        bus.ex_wb_npc = '0;       bus.ex_wb_redirect = 1'b0;
        bus.lsb_wb_valid = 1'b0;  bus.lsb_wb_tag = '0; bus.lsb_wb_data = '0;
        bus.lsb_wb_addr = '0;     bus.st_done = 1'b0;  bus.hzd_addr = '0;

        tick();
        tick();
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_alloc_tag", bus.alloc_tag, 0);
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_flush_out", bus.flush_out, 0);
        chk("rst_hzd", bus.hzd, 0);
        rst = 1'b0;

        // Fill all four entries
        for (int i = 0; i < 4; i++) begin
            chk("fill_tag", bus.alloc_tag, i);
            do_alloc(c_OP_ADDI, 5'(i + 1));
        end
        chk("full_count", bus.count, 4);
        chk("full_alloc_ready", bus.alloc_ready, 0);
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        chk("full_reject_count", bus.count, 4);
        chk("full_reject_tail", bus.alloc_tag, 0);

        ex_wb(2'd0, 32'h5, 32'h0, 1'b0);
        tick();
        wb_idle();
        chk("wb0_cdb_valid", bus.cdb_ex_valid, 1);
        chk("wb0_cdb_data", bus.cdb_ex_data, 32'h5);
        chk("wb0_no_commit_yet", bus.commit_valid, 0);
        chk("wb0_still_full", bus.alloc_ready, 0);
        bus.q1_tag = 2'd0;
        #1;
        chk("wb0_q1_ready", bus.q1_ready, 1);
        chk("wb0_q1_data", bus.q1_data, 32'h5);
        tick();
        chk("c0_valid", bus.commit_valid, 1);
        chk("c0_data", bus.commit_data, 32'h5);
        chk("c0_rd", bus.commit_rd, 1);
        chk("c0_tag", bus.commit_tag, 0);
        chk("c0_count", bus.count, 3);
        chk("c0_alloc_ready", bus.alloc_ready, 1);

        // Out-of-order writeback, in-order retirement
        ex_wb(2'd3, 32'h33, 32'h0, 1'b0);
        tick();
        wb_idle();
        chk("wb3_cdb_tag", bus.cdb_ex_tag, 3);
        tick();
        chk("wb3_head_blocks", bus.commit_valid, 0);
        ex_wb(2'd1, 32'h11, 32'h0, 1'b0);
        lsb_wb(2'd2, 32'h22, 32'h0);
        tick();
        wb_idle();
        chk("dual_ex_valid", bus.cdb_ex_valid, 1);
        chk("dual_ex_tag", bus.cdb_ex_tag, 1);
        chk("dual_ex_data", bus.cdb_ex_data, 32'h11);
        chk("dual_lsb_valid", bus.cdb_lsb_valid, 1);
        chk("dual_lsb_tag", bus.cdb_lsb_tag, 2);
        chk("dual_lsb_data", bus.cdb_lsb_data, 32'h22);
        chk("dual_no_commit", bus.commit_valid, 0);
        tick();
        chk("c1_tag", bus.commit_tag, 1);
        chk("c1_data", bus.commit_data, 32'h11);
        tick();
        chk("c2_tag", bus.commit_tag, 2);
        chk("c2_data", bus.commit_data, 32'h22);
        chk("c2_rd", bus.commit_rd, 3);
        tick();
        chk("c3_tag", bus.commit_tag, 3);
        chk("c3_data", bus.commit_data, 32'h33);
        chk("c3_count", bus.count, 0);
        tick();
        chk("empty_no_commit", bus.commit_valid, 0);

        // Same tag on both ports: EX wins
        do_alloc(c_OP_ADDI, 5'd7);
        ex_wb(2'd0, 32'h77, 32'h0, 1'b0);
        lsb_wb(2'd0, 32'h99, 32'h0);
        tick();
        wb_idle();
        chk("same_ex_valid", bus.cdb_ex_valid, 1);
        chk("same_lsb_dropped", bus.cdb_lsb_valid, 0);
        tick();
        chk("same_commit_data", bus.commit_data, 32'h77);
        chk("same_commit_rd", bus.commit_rd, 7);

        // SW at head, delayed st_done
        do_alloc(c_OP_SW, 5'd0);
        bus.hzd_addr = 32'h1000;
        #1;
        chk("sw_hzd_not_ready", bus.hzd, 0);
        lsb_wb(2'd1, 32'hDEADBEEF, 32'h1000);
        tick();
        wb_idle();
        chk("sw_hzd_ready", bus.hzd, 1);
        tick();
        chk("sw_st_req", bus.st_req, 1);
        chk("sw_st_addr", bus.st_addr, 32'h1000);
        chk("sw_st_data", bus.st_data, 32'hDEADBEEF);
        chk("sw_st_size", bus.st_size, 4);
        chk("sw_no_commit", bus.commit_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_wait_req_low", bus.st_req, 0);
            chk("sw_wait_count", bus.count, 1);
        end
        bus.st_done = 1'b1;
        tick();
        bus.st_done = 1'b0;
        chk("sw_retired_count", bus.count, 0);
        chk("sw_retired_hzd", bus.hzd, 0);
        chk("sw_tail", bus.alloc_tag, 2);

        // Pending store hazard
        do_alloc(c_OP_SW, 5'd0);
        lsb_wb(2'd2, 32'h1234, 32'h1004);
        tick();
        wb_idle();
        bus.hzd_addr = 32'h1006;
        #1;
        chk("hzd_same_word", bus.hzd, 1);
        bus.hzd_addr = 32'h1008;
        #1;
        chk("hzd_next_word", bus.hzd, 0);
        tick();
        chk("hzd_st_req", bus.st_req, 1);
        bus.st_done = 1'b1;
        tick();
        bus.st_done = 1'b0;
        chk("hzd_st_retired", bus.count, 0);

        // Mispredicted branch with three younger entries
        do_alloc(c_OP_BEQ, 5'd0);
        do_alloc(c_OP_ADDI, 5'd1);
        do_alloc(c_OP_ADDI, 5'd2);
        do_alloc(c_OP_ADDI, 5'd3);
        chk("br_count", bus.count, 4);
        ex_wb(2'd3, 32'h0, 32'h200, 1'b1);
        tick();
        wb_idle();
        tick();
        chk("br_redirect_valid", bus.redirect_valid, 1);
        chk("br_redirect_pc", bus.redirect_pc, 32'h200);
        chk("br_no_commit", bus.commit_valid, 0);
        chk("br_flush_not_yet", bus.flush_out, 0);
        tick();
        chk("br_flush_out", bus.flush_out, 1);
        chk("br_redirect_low", bus.redirect_valid, 0);
        chk("br_count_zero", bus.count, 0);
        chk("br_tail_zero", bus.alloc_tag, 0);
        tick();
        chk("br_flush_low", bus.flush_out, 0);
        chk("br_alloc_ready", bus.alloc_ready, 1);

        // JAL commits its link value and redirects
        do_alloc(c_OP_JAL, 5'd1);
        ex_wb(2'd0, 32'h104, 32'h400, 1'b1);
        tick();
        wb_idle();
        tick();
        chk("jal_commit_valid", bus.commit_valid, 1);
        chk("jal_commit_data", bus.commit_data, 32'h104);
        chk("jal_redirect_pc", bus.redirect_pc, 32'h400);
        tick();
        chk("jal_flush_out", bus.flush_out, 1);
        chk("jal_count", bus.count, 0);
        tick();

        // Same-cycle lookup of a zero-valued writeback
        for (int i = 0; i < 4; i++) do_alloc(c_OP_ADDI, 5'(i + 8));
        bus.q1_tag = 2'd3;
        bus.q2_tag = 2'd2;
        ex_wb(2'd3, 32'h0, 32'h0, 1'b0);
        lsb_wb(2'd2, 32'h55, 32'h0);
        #1;
        chk("byp_q1_ready", bus.q1_ready, c_BYP);
        chk("byp_q1_data", bus.q1_data, 0);
        chk("byp_q2_ready", bus.q2_ready, c_BYP);
        chk("byp_q2_data", bus.q2_data, c_BYP ? 32'h55 : 32'h0);
        tick();
        wb_idle();
        chk("reg_q1_ready", bus.q1_ready, 1);
        chk("reg_q1_data", bus.q1_data, 0);
        chk("reg_q2_data", bus.q2_data, 32'h55);

        // External clear
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_count", bus.count, 0);
        chk("clr_alloc_ready", bus.alloc_ready, 1);
        chk("clr_q1_ready", bus.q1_ready, 0);

        // Global stall
        bus.rdy = 1'b0;
        bus.alloc_valid = 1'b1;
        tick();
        chk("stall_count", bus.count, 0);
        bus.rdy = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        chk("unstall_count", bus.count, 1);
        bus.rdy = 1'b0;
        ex_wb(2'd0, 32'h9, 32'h0, 1'b0);
        tick();
        wb_idle();
        chk("stall_cdb_low", bus.cdb_ex_valid, 0);
        bus.rdy = 1'b1;
        tick();
        chk("stall_wb_dropped", bus.commit_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
